// File: rtl/mem_access_stage.sv
// MEM stage: runs lw/sw on a variable-latency req/ack data bus, zero latency for non-memory ops.
// Freezes upstream (stall_o) and feeds MEM_WB a bubble while a transfer is outstanding.
module mem_access_stage #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [1:0]  WB_i,
  input  logic [1:0]  M_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  input  logic [4:0]  MUX3_i,
  output logic [1:0]  WB_o,
  output logic [31:0] ReadData_o,
  output logic [31:0] addr_o,
  output logic [4:0]  MUX3_o,
  output logic        stall_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_ack_i,
  input  logic [31:0] mem_rdata_i,
  output logic        err_o
);

  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t        state_q, state_d;
  logic          mem_req_q, mem_req_d;
  logic          mem_we_q, mem_we_d;
  logic [31:0]   mem_addr_q, mem_addr_d;
  logic [31:0]   mem_wdata_q, mem_wdata_d;
  logic [CW-1:0] wait_cnt_q, wait_cnt_d;
  logic          err_q, err_d;

  logic access;
  logic aligned;

  assign access  = M_i[1] | M_i[0];
  assign aligned = (addr_i[1:0] == 2'b00);

  assign addr_o      = addr_i;
  assign MUX3_o      = MUX3_i;
  assign mem_req_o   = mem_req_q;
  assign mem_we_o    = mem_we_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;
  assign err_o       = err_q;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q     <= IDLE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= 32'd0;
      mem_wdata_q <= 32'd0;
      wait_cnt_q  <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      wait_cnt_q  <= wait_cnt_d;
      err_q       <= err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    wait_cnt_d  = wait_cnt_q;
    err_d       = err_q;
    stall_o     = 1'b0;
    WB_o        = WB_i;
    ReadData_o  = 32'd0;

    case (state_q)
      IDLE: begin
        if (access) begin
          WB_o = 2'b00;
          if (!aligned) begin
            // Misaligned access is dropped without stalling; only the sticky flag records it.
            err_d = 1'b1;
          end else begin
            stall_o     = 1'b1;
            state_d     = BUSY;
            mem_req_d   = 1'b1;
            mem_we_d    = M_i[0];
            mem_addr_d  = addr_i;
            mem_wdata_d = wdata_i;
            wait_cnt_d  = '0;
          end
        end
      end
      BUSY: begin
        if (mem_ack_i) begin
          state_d    = IDLE;
          mem_req_d  = 1'b0;
          ReadData_o = mem_we_q ? 32'd0 : mem_rdata_i;
        end else if (wait_cnt_q == CW'(TIMEOUT - 1)) begin
          WB_o      = 2'b00;
          err_d     = 1'b1;
          state_d   = IDLE;
          mem_req_d = 1'b0;
        end else begin
          stall_o    = 1'b1;
          WB_o       = 2'b00;
          wait_cnt_d = wait_cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    // While reset is held the stage behaves as a plain pass-through.
    if (!rst_i) begin
      stall_o    = 1'b0;
      WB_o       = WB_i;
      ReadData_o = 32'd0;
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage: scoreboard of retired MEM_WB results and memory requests.
module tb_mem_access_stage;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [1:0]  WB_i, M_i;
  logic [31:0] addr_i, wdata_i;
  logic [4:0]  MUX3_i;
  logic [1:0]  WB_o;
  logic [31:0] ReadData_o, addr_o;
  logic [4:0]  MUX3_o;
  logic        stall_o, mem_req_o, mem_we_o;
  logic [31:0] mem_addr_o, mem_wdata_o;
  logic        mem_ack_i;
  logic [31:0] mem_rdata_i;
  logic        err_o;

  always #5 clk_i = ~clk_i;

  mem_access_stage #(.TIMEOUT(16)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .WB_i(WB_i), .M_i(M_i), .addr_i(addr_i),
    .wdata_i(wdata_i), .MUX3_i(MUX3_i), .WB_o(WB_o), .ReadData_o(ReadData_o),
    .addr_o(addr_o), .MUX3_o(MUX3_o), .stall_o(stall_o), .mem_req_o(mem_req_o),
    .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .mem_ack_i(mem_ack_i), .mem_rdata_i(mem_rdata_i), .err_o(err_o)
  );

  typedef struct {
    logic [1:0]  wb;
    logic [31:0] rd;
    logic [31:0] addr;
    logic [4:0]  mux3;
  } res_t;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_t;

  res_t exp_q[$];
  req_t req_q[$];

  int checks = 0;
  int errors = 0;
  int ack_delay = 0;
  logic [31:0] rdata_cfg = 32'd0;
  int req_rises = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Memory responder: acks ack_delay BUSY cycles after the request rises (-1 = never).
  initial begin
    bit req_seen;
    int cyc;
    req_seen = 0;
    cyc = 0;
    mem_ack_i = 1'b0;
    mem_rdata_i = 32'd0;
    forever begin
      @(posedge clk_i);
      #1;
      mem_ack_i = 1'b0;
      if (mem_req_o) begin
        if (!req_seen) begin
          req_seen = 1;
          cyc = 0;
          req_rises++;
          if (req_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_req: got addr 0x%08h expected no request", mem_addr_o);
          end else begin
            req_t r;
            r = req_q.pop_front();
            chk("req_we", {31'd0, mem_we_o}, {31'd0, r.we});
            chk("req_addr", mem_addr_o, r.addr);
            chk("req_wdata", mem_wdata_o, r.wdata);
          end
        end else begin
          cyc++;
        end
        if (ack_delay >= 0 && cyc == ack_delay) begin
          mem_ack_i = 1'b1;
          mem_rdata_i = rdata_cfg;
        end
      end else begin
        req_seen = 0;
      end
    end
  end

  // Result monitor: every non-stalled cycle out of reset hands one result to MEM_WB.
  initial begin
    forever begin
      @(negedge clk_i);
      if (rst_i && !stall_o) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_result: got WB 0x%0h expected none", WB_o);
        end else begin
          res_t e;
          e = exp_q.pop_front();
          chk("wb_o", {30'd0, WB_o}, {30'd0, e.wb});
          chk("readdata_o", ReadData_o, e.rd);
          chk("addr_o", addr_o, e.addr);
          chk("mux3_o", {27'd0, MUX3_o}, {27'd0, e.mux3});
        end
      end
    end
  end

  // Drives one instruction, holds it while stalled, returns the stall cycle count.
  task automatic run_instr(input logic [1:0] wb, input logic [1:0] m, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [4:0] rd,
                           input logic [1:0] exp_wb, input logic [31:0] exp_rd,
                           output int stalls);
    res_t e;
    bit done;
    e.wb = exp_wb; e.rd = exp_rd; e.addr = addr; e.mux3 = rd;
    exp_q.push_back(e);
    WB_i = wb; M_i = m; addr_i = addr; wdata_i = wdata; MUX3_i = rd;
    stalls = 0;
    done = 0;
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge clk_i);
      if (!stall_o) done = 1;
      else stalls++;
    end
    if (!done) begin
      checks++; errors++;
      $display("FAIL stall_bound: got %0d stall cycles expected release", stalls);
    end
    @(posedge clk_i);
    #1;
  endtask

  task automatic nop();
    int s;
    run_instr(2'b00, 2'b00, 32'h0000_0000, 32'd0, 5'd0, 2'b00, 32'd0, s);
  endtask

  initial begin
    int s;
    req_t r;
    rst_i = 1'b0;
    WB_i = 2'b10; M_i = 2'b01; addr_i = 32'h0000_0040; wdata_i = 32'h1; MUX3_i = 5'd3;
    #12;
    chk("rst_stall", {31'd0, stall_o}, 32'd0);
    chk("rst_wb_pass", {30'd0, WB_o}, 32'd2);
    chk("rst_req", {31'd0, mem_req_o}, 32'd0);
    chk("rst_we", {31'd0, mem_we_o}, 32'd0);
    chk("rst_maddr", mem_addr_o, 32'd0);
    chk("rst_mwdata", mem_wdata_o, 32'd0);
    chk("rst_err", {31'd0, err_o}, 32'd0);
    chk("rst_readdata", ReadData_o, 32'd0);
    @(posedge clk_i); #1;
    WB_i = 2'b00; M_i = 2'b00;
    @(posedge clk_i); #1;
    rst_i = 1'b1;

    // add: pure pass-through
    run_instr(2'b10, 2'b00, 32'h0000_0010, 32'd0, 5'd1, 2'b10, 32'd0, s);
    chk("add_stalls", s, 32'd0);
    chk("add_no_req", req_rises, 32'd0);

    // lw, ack three cycles after request
    ack_delay = 3; rdata_cfg = 32'hDEAD_BEEF;
    r.we = 1'b0; r.addr = 32'h0000_0040; r.wdata = 32'h0000_0AAA; req_q.push_back(r);
    run_instr(2'b11, 2'b10, 32'h0000_0040, 32'h0000_0AAA, 5'd5, 2'b11, 32'hDEAD_BEEF, s);
    chk("lw_stalls", s, 32'd4);
    chk("lw_req_drop", {31'd0, mem_req_o}, 32'd0);

    // sw, zero-wait ack; read data must be masked even though the bus returns data
    ack_delay = 0; rdata_cfg = 32'hFFFF_FFFF;
    r.we = 1'b1; r.addr = 32'h0000_0044; r.wdata = 32'h1234_5678; req_q.push_back(r);
    run_instr(2'b00, 2'b01, 32'h0000_0044, 32'h1234_5678, 5'd0, 2'b00, 32'd0, s);
    chk("sw_stalls", s, 32'd1);
    chk("err_clear", {31'd0, err_o}, 32'd0);

    // both MemRead and MemWrite set: write wins
    r.we = 1'b1; r.addr = 32'h0000_0048; r.wdata = 32'h0BAD_F00D; req_q.push_back(r);
    run_instr(2'b00, 2'b11, 32'h0000_0048, 32'h0BAD_F00D, 5'd0, 2'b00, 32'd0, s);
    chk("rw_stalls", s, 32'd1);

    // misaligned lw: dropped, sticky error
    s = req_rises;
    begin
      int st;
      run_instr(2'b11, 2'b10, 32'h0000_0042, 32'd0, 5'd7, 2'b00, 32'd0, st);
      chk("mis_stalls", st, 32'd0);
    end
    chk("mis_no_req", req_rises, s);
    chk("mis_err", {31'd0, err_o}, 32'd1);
    nop(); nop();
    chk("mis_err_sticky", {31'd0, err_o}, 32'd1);

    // reset in the middle of a transfer
    ack_delay = -1;
    r.we = 1'b0; r.addr = 32'h0000_0080; r.wdata = 32'd0; req_q.push_back(r);
    WB_i = 2'b11; M_i = 2'b10; addr_i = 32'h0000_0080; wdata_i = 32'd0; MUX3_i = 5'd9;
    repeat (3) @(posedge clk_i);
    #1;
    chk("busy_req", {31'd0, mem_req_o}, 32'd1);
    rst_i = 1'b0;
    #1;
    chk("rstbusy_req", {31'd0, mem_req_o}, 32'd0);
    chk("rstbusy_stall", {31'd0, stall_o}, 32'd0);
    chk("rstbusy_err", {31'd0, err_o}, 32'd0);
    WB_i = 2'b00; M_i = 2'b00;
    repeat (2) @(posedge clk_i);
    #1;
    rst_i = 1'b1;
    #1;
    chk("post_rst_stall", {31'd0, stall_o}, 32'd0);

    // next lw works normally
    ack_delay = 1; rdata_cfg = 32'hCAFE_0001;
    r.we = 1'b0; r.addr = 32'h0000_0100; r.wdata = 32'd0; req_q.push_back(r);
    run_instr(2'b11, 2'b10, 32'h0000_0100, 32'd0, 5'd12, 2'b11, 32'hCAFE_0001, s);
    chk("lw2_stalls", s, 32'd2);
    chk("lw2_err", {31'd0, err_o}, 32'd0);

    // timeout: never acked
    ack_delay = -1;
    r.we = 1'b0; r.addr = 32'h0000_0200; r.wdata = 32'd0; req_q.push_back(r);
    run_instr(2'b11, 2'b10, 32'h0000_0200, 32'd0, 5'd4, 2'b00, 32'd0, s);
    chk("to_stalls", s, 32'd16);
    chk("to_req_drop", {31'd0, mem_req_o}, 32'd0);
    chk("to_err", {31'd0, err_o}, 32'd1);
    nop();

    chk("exp_q_empty", exp_q.size(), 32'd0);
    chk("req_q_empty", req_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
